// File: rtl/seq_pkg.sv
// Shared types and sizes for the datapath sequencer.
// Memory B holds one ALU result per word pair of memory A.
package seq_pkg;

  localparam int DEPTH_A = 8;
  localparam int AW_A    = 3;
  localparam int DEPTH_B = DEPTH_A / 2;
  localparam int AW_B    = AW_A - 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DONE,
    DRAIN
  } state_t;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Control handshake between the sequencer and its environment.
// SEQ_ABORT_EN adds the abort request line.
interface datapath_sequencer_if;

  logic start;
  logic in_valid;
  logic in_ready;
  logic weA;
  logic incA;
  logic weB;
  logic incB;
  logic busy;
  logic done;

`ifdef SEQ_ABORT_EN
  logic abort;

  modport master (
    output start, in_valid, abort,
    input  in_ready, weA, incA,
    input  weB, incB, busy, done
  );

  modport slave (
    input  start, in_valid, abort,
    output in_ready, weA, incA,
    output weB, incB, busy, done
  );
`else
  modport master (
    output start, in_valid,
    input  in_ready, weA, incA,
    input  weB, incB, busy, done
  );

  modport slave (
    input  start, in_valid,
    output in_ready, weA, incA,
    output weB, incB, busy, done
  );
`endif

endinterface

// File: rtl/seq_shadow_cnt.sv
// Wrapping up-counter mirroring an external address counter.
// Wraps at 2**W, matching the memory depth.
module seq_shadow_cnt #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Sequencer for the A-memory -> delay -> ALU -> B-memory datapath.
// Define SEQ_ABORT_EN to add abort with counter drain.
module datapath_sequencer
  import seq_pkg::*;
(
  input logic                 clock,
  input logic                 reset,
  datapath_sequencer_if.slave bus
);

  state_t state;
  state_t next;

  logic [AW_A-1:0] cntA;
  logic [AW_B-1:0] cntB;

  logic inReady;
  logic weA;
  logic incA;
  logic weB;
  logic incB;
  logic lastA;
  logic abortReq;

  assign lastA = (cntA == AW_A'(DEPTH_A - 1));

`ifdef SEQ_ABORT_EN
  assign abortReq = bus.abort &&
                    (state == LOAD || state == COMPUTE);
`else
  assign abortReq = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next    = state;
    inReady = 1'b0;
    weA     = 1'b0;
    incA    = 1'b0;
    weB     = 1'b0;
    incB    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) next = LOAD;
      end
      LOAD: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          weA  = 1'b1;
          incA = 1'b1;
          if (lastA) next = COMPUTE;
        end
      end
      COMPUTE: begin
        // odd address: delay holds the even partner
        incA = 1'b1;
        weB  = cntA[0];
        incB = cntA[0];
        if (lastA) next = DONE;
      end
      DONE: begin
        next = IDLE;
      end
      DRAIN: begin
`ifdef SEQ_ABORT_EN
        incA = (cntA != '0);
        incB = (cntB != '0);
        if (cntA == '0 && cntB == '0) next = IDLE;
`else
        next = IDLE;
`endif
      end
      default: begin
        next = IDLE;
      end
    endcase
    if (abortReq) begin
      next    = DRAIN;
      inReady = 1'b0;
      weA     = 1'b0;
      incA    = 1'b0;
      weB     = 1'b0;
      incB    = 1'b0;
    end
  end

  seq_shadow_cnt #(.W(AW_A)) uCntA (
    .clock (clock),
    .reset (reset),
    .inc   (incA),
    .cnt   (cntA)
  );

  seq_shadow_cnt #(.W(AW_B)) uCntB (
    .clock (clock),
    .reset (reset),
    .inc   (incB),
    .cnt   (cntB)
  );

  assign bus.in_ready = inReady;
  assign bus.weA      = weA;
  assign bus.incA     = incA;
  assign bus.weB      = weB;
  assign bus.incB     = incB;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer with a memory/ALU environment model.
// Build with SEQ_ABORT_EN to also exercise abort.
module tb_datapath_sequencer;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  datapath_sequencer_if bus();

  datapath_sequencer dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  typedef logic [7:0] words_t [DEPTH_A];

  typedef struct {
    int         addr;
    logic [7:0] data;
  } sb_t;

  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic [6:0] exp;
  } vec_t;

  logic [7:0]      dataIn;
  logic [7:0]      memA [DEPTH_A];
  logic [7:0]      memB [DEPTH_B];
  logic [AW_A-1:0] counterA;
  logic [AW_B-1:0] counterB;
  logic [7:0]      delayReg;

  sb_t  expB[$];
  int   nCmp = 0;
  int   nBad = 0;
  int   weACount = 0;
  int   doneCount = 0;
  vec_t vecs[19];
  words_t w1;
  words_t w2;

  function automatic logic [7:0] alu(logic [7:0] a, logic [7:0] b);
    return {a[3:0], b[3:0]};
  endfunction

  function automatic logic [6:0] outs();
    return {bus.in_ready, bus.weA, bus.incA,
            bus.weB, bus.incB, bus.busy, bus.done};
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // external counters, memories, delay register and ALU
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counterA <= '0;
      counterB <= '0;
      delayReg <= '0;
    end else begin
      if (bus.weA) memA[counterA] <= dataIn;
      delayReg <= memA[counterA];
      if (bus.weB) memB[counterB] <= alu(delayReg, memA[counterA]);
      if (bus.incA) counterA <= counterA + 1'b1;
      if (bus.incB) counterB <= counterB + 1'b1;
    end
  end

  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (bus.weA) weACount++;
      if (bus.done) doneCount++;
      if (bus.weB) begin
        if (expB.size() == 0) begin
          check("sb underflow", 1, 0);
        end else begin
          e = expB.pop_front();
          check("B addr", 32'(counterB), e.addr);
          check("B data", alu(delayReg, memA[counterA]), e.data);
        end
      end
    end
  end

  task automatic pushPairs(input words_t w);
    for (int j = 0; j < DEPTH_B; j++)
      expB.push_back('{j, alu(w[2*j], w[2*j+1])});
  endtask

  task automatic checkB(input words_t w, input string tag);
    for (int j = 0; j < DEPTH_B; j++)
      check($sformatf("%s memB%0d", tag, j), memB[j],
            alu(w[2*j], w[2*j+1]));
  endtask

  task automatic checkShadow(input string tag);
    check({tag, " shadow"}, {dut.cntA, dut.cntB},
          {counterA, counterB});
    check({tag, " cnt0"}, {counterA, counterB}, 0);
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  // start cycle, then load all words; ends at the last accept negedge
  task automatic loadRun(input words_t w, input bit stall,
                         input bit poke);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    nextCyc();
    bus.start = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("idle ready", bus.in_ready, 0);
    while (idx < DEPTH_A && cyc < 40) begin
      nextCyc();
      bus.start = poke && (cyc == 2);
      bus.in_valid = stall ? (cyc % 2 == 0) : 1'b1;
      dataIn = w[idx];
      @(negedge clk);
      check("load weA", bus.weA, bus.in_valid);
      if (bus.in_valid) idx++;
      cyc++;
    end
    check("load count", idx, DEPTH_A);
    nextCyc();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic runSeq(input words_t w, input bit stall,
                        input bit poke, input string tag);
    int w0;
    int d0;
    w0 = weACount;
    d0 = doneCount;
    pushPairs(w);
    loadRun(w, stall, poke);
    for (int k = 0; k < DEPTH_A; k++) begin
      @(negedge clk);
      check($sformatf("%s k%0d", tag, k), {bus.incA, bus.weB},
            {1'b1, 1'(k % 2)});
      nextCyc();
    end
    bus.start = poke;
    @(negedge clk);
    check({tag, " done"}, {bus.busy, bus.done}, 2'b11);
    nextCyc();
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, " idle"}, {bus.busy, bus.done}, 2'b00);
    check({tag, " weA n"}, weACount - w0, DEPTH_A);
    check({tag, " done n"}, doneCount - d0, 1);
    check({tag, " sb"}, expB.size(), 0);
    checkB(w, tag);
    checkShadow(tag);
  endtask

  initial begin
    int doneCyc;
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int doneCyc;
    w1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    w2 = '{8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h00};

    vecs[0] = '{1'b1, 1'b1, 8'hAA, 7'b0000000};
    for (int i = 1; i <= DEPTH_A; i++)
      vecs[i] = '{1'b0, 1'b1, 8'(i), 7'b1110010};
    for (int i = 0; i < DEPTH_A; i++)
      vecs[9+i] = '{1'b0, 1'b0, 8'h00,
                    {2'b00, 1'b1, 1'(i % 2), 1'(i % 2), 2'b10}};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 7'b0000011};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 7'b0000000};

    bus.start = 1'b0;
    bus.in_valid = 1'b0;
`ifdef SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    dataIn = '0;
    @(negedge clk);
    check("reset outs", outs(), 0);
    check("reset shadow", {dut.cntA, dut.cntB}, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("idle outs", outs(), 0);

    // nominal run, cycle by cycle
    doneCyc = 0;
    pushPairs(w1);
    for (int i = 0; i < 19; i++) begin
      nextCyc();
      bus.start = vecs[i].start;
      bus.in_valid = vecs[i].valid;
      dataIn = vecs[i].data;
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      if (bus.done && doneCyc == 0) doneCyc = i + 1;
    end
    check("done cycle", doneCyc, 18);
    check("vec weA n", weACount, DEPTH_A);
    check("vec done n", doneCount, 1);
    check("vec sb", expB.size(), 0);
    checkB(w1, "vec");
    checkShadow("vec");

    // reset in the middle of COMPUTE
    pushPairs(w1);
    loadRun(w1, 1'b0, 1'b0);
    repeat (3) nextCyc();
    rst_n = 1'b0;
    #1;
    check("rst outs", outs(), 0);
    check("rst shadow", {dut.cntA, dut.cntB}, 0);
    check("rst cnt", {counterA, counterB}, 0);
    expB.delete();
    #2 rst_n = 1'b1;
    nextCyc();
    bus.start = 1'b1;
    nextCyc();
    bus.start = 1'b0;
    @(negedge clk);
    check("rst ready", bus.in_ready, 1);
    nextCyc();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst idle", bus.busy, 0);

    runSeq(w1, 1'b1, 1'b0, "stall");
    runSeq(w2, 1'b0, 1'b1, "poke");
    runSeq(w1, 1'b0, 1'b0, "b2b1");
    runSeq(w2, 1'b0, 1'b0, "b2b2");

`ifdef SEQ_ABORT_EN
    begin
      int d0;
      int nIncA;
      int nIncB;
      int nWeB;
      int c;
      d0 = doneCount;
      nIncA = 0;
      nIncB = 0;
      nWeB = 0;
      pushPairs(w1);
      loadRun(w1, 1'b0, 1'b0);
      repeat (3) nextCyc();
      bus.abort = 1'b1;
      @(negedge clk);
      check("abort wins", {bus.incA, bus.weB}, 0);
      nextCyc();
      bus.abort = 1'b0;
      c = 0;
      @(negedge clk);
      while (bus.busy && c < 20) begin
        nIncA += int'(bus.incA);
        nIncB += int'(bus.incB);
        nWeB += int'(bus.weB) + int'(bus.done);
        c++;
        @(negedge clk);
      end
      check("drain end", bus.busy, 0);
      check("drain incA", nIncA, 5);
      check("drain incB", nIncB, 3);
      check("drain weB", nWeB, 0);
      check("abort done", doneCount - d0, 0);
      check("abort sb", expB.size(), 3);
      expB.delete();
      checkShadow("abort");
      runSeq(w2, 1'b0, 1'b0, "post");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
